// File: rtl/pll_reset_sequencer_pkg.sv
// pll_seq_pkg: state encoding and counter sizing helper for the PLL reset sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
    return r;
  endfunction
endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: PLL control/status bundle between the sequencer and its surroundings
interface pll_reset_sequencer_if;
  logic       pll_lock_i;
  logic       pll_resetb_o;
  logic       sys_reset_o;
  logic       ready_o;
  logic       fault_o;
  logic [2:0] state_o;
  logic [3:0] retry_count_o;
  logic [7:0] lock_loss_count_o;
  modport master (
    input  pll_lock_i,
    output pll_resetb_o, sys_reset_o, ready_o, fault_o, state_o, retry_count_o, lock_loss_count_o
  );
  modport slave (
    output pll_lock_i,
    input  pll_resetb_o, sys_reset_o, ready_o, fault_o, state_o, retry_count_o, lock_loss_count_o
  );
endinterface

// File: rtl/pll_reset_sequencer_sync_ff.sv
// sync_ff: multi-flop synchroniser bringing an asynchronous level into the clk domain
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  // shift the raw input through the chain, cleared by reset
  always_ff @(posedge clk)
    sync_q <= reset ? '0 : {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL RESETB, waits for stable lock, then releases the display reset
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 16000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int SYNC_STAGES   = 2
) (
  input logic                  clk,
  input logic                  reset,
  pll_reset_sequencer_if.master bus
);
  localparam int CMAX = (RESET_CYCLES > LOCK_TIMEOUT) ?
                        ((RESET_CYCLES > STABLE_CYCLES) ? RESET_CYCLES : STABLE_CYCLES) :
                        ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
  localparam int CW = (clog2(CMAX) > 0) ? clog2(CMAX) : 1;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          resetb_q, sys_reset_q, ready_q, fault_q;
  logic          lock_s;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.pll_lock_i),
    .q_o   (lock_s)
  );
  // next state and retry/loss bookkeeping; lock beats a coincident timeout
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      PLL_RST:   state_d = (cnt_q == CW'(RESET_CYCLES - 1)) ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK: begin
        if (lock_s) state_d = STABLE;
        else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_d == 4'(MAX_RETRIES)) ? FAULT : PLL_RST;
        end
      end
      STABLE:    state_d = !lock_s ? WAIT_LOCK : (cnt_q == CW'(STABLE_CYCLES - 1)) ? RUN : STABLE;
      RUN: begin
        if (!lock_s) begin
          state_d = PLL_RST;
          loss_d  = (loss_q == 8'hff) ? loss_q : loss_q + 8'd1;
        end
      end
      FAULT:     state_d = FAULT;
      default:   state_d = PLL_RST;
    endcase
    retry_d = (state_d == RUN) ? 4'd0 : retry_d;
  end
  // state, cycle counter and outputs registered from the state being entered
  always_ff @(posedge clk)
    if (reset) begin
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      resetb_q    <= 1'b0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= (state_d != state_q) ? '0 :
                     (state_q inside {PLL_RST, WAIT_LOCK, STABLE}) ? cnt_q + 1'b1 : cnt_q;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      resetb_q    <= state_d inside {WAIT_LOCK, STABLE, RUN};
      sys_reset_q <= state_d != RUN;
      ready_q     <= state_d == RUN;
      fault_q     <= state_d == FAULT;
    end
  assign bus.pll_resetb_o      = resetb_q;
  assign bus.sys_reset_o       = sys_reset_q;
  assign bus.ready_o           = ready_q;
  assign bus.fault_o           = fault_q;
  assign bus.state_o           = state_q;
  assign bus.retry_count_o     = retry_q;
  assign bus.lock_loss_count_o = loss_q;
endmodule
